// File: rtl/reg_serial_reader.sv
// -----------------------------------------------------------------------------
// reg_serial_reader
//
// Reader-side companion to the parallel load/store register. A word presented
// on `in` is captured when `load` is seen in IDLE. It is then unloaded one bit
// per beat on a valid/ready serial port, MSB or LSB first. When the macro
// REG_READER_PARITY_EN is defined, one extra even-parity beat follows the data
// beats. Without the macro the PARITY state and the parity logic are not built.
//
// Parameters
//   N          data word width in bits (N >= 2)
//   MSB_FIRST  1: bit N-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         rising-edge clock
//   clear       synchronous active-high reset; wins over every other input
//   in          parallel word, sampled only on the capture edge
//   load        capture request, honoured only in IDLE
//   sout        current serial bit (0 whenever sout_valid = 0)
//   sout_valid  sout holds a beat
//   sout_ready  downstream accepts the beat this cycle
//   busy        transfer in progress (SHIFT or PARITY)
//   done        one-cycle pulse after the final beat is accepted
//   bits_left   data beats remaining, including the current one
//
// Optional feature macro: REG_READER_PARITY_EN
// -----------------------------------------------------------------------------
module reg_serial_reader #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [N-1:0]           in,
    input  logic                   load,
    output logic                   sout,
    output logic                   sout_valid,
    input  logic                   sout_ready,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(N+1)-1:0] bits_left
);

    localparam int BL_W = $clog2(N+1);

`ifdef REG_READER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    shreg;
    logic [BL_W-1:0] bl_q;
    logic            out_bit;
    logic [N-1:0]    shreg_shifted;
    logic            beat_accept;
    logic            last_beat;

`ifdef REG_READER_PARITY_EN
    // Even parity of the captured word, computed once at capture. The shift
    // register is consumed as the data leaves, so the parity cannot be
    // derived from it later.
    logic            par_q;
`endif

    // The bit at the output end of the register, and the register after one
    // beat has left. The shift moves toward the output end and fills with 0.
    assign out_bit       = MSB_FIRST ? shreg[N-1] : shreg[0];
    assign shreg_shifted = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};

    assign beat_accept   = sout_valid & sout_ready;
    assign last_beat     = (bl_q == BL_W'(1));

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sout_ready && last_beat) begin
`ifdef REG_READER_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef REG_READER_PARITY_EN
            S_PARITY: begin
                if (sout_ready) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // DONE lasts exactly one cycle. A load seen here is dropped.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- output logic ----
    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_SHIFT: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = out_bit;
            end
`ifdef REG_READER_PARITY_EN
            S_PARITY: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = par_q;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bits_left = bl_q;

    // ---- shift register and beat counter ----
    // bits_left reaches 0 on the last data beat. It therefore reads 0 in
    // PARITY, DONE and IDLE without needing a separate clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            shreg <= '0;
            bl_q  <= '0;
        end else if (state == S_IDLE && load) begin
            shreg <= in;
            bl_q  <= BL_W'(N);
        end else if (state == S_SHIFT && beat_accept) begin
            shreg <= shreg_shifted;
            bl_q  <= bl_q - BL_W'(1);
        end
    end

`ifdef REG_READER_PARITY_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            par_q <= 1'b0;
        end else if (state == S_IDLE && load) begin
            par_q <= ^in;
        end
    end
`endif

endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
- Reader-side companion to the parallel load/store register.
- Captures an N-bit parallel word on a load request and unloads it one bit per beat on a serial port.
- Serial port uses a valid/ready handshake.
- Used wherever a stored register value must be read out bit-serially, e.g. to a display shifter or serial link.

Parameters:
- N, 8, data word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = shift out bit N-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  reset, synchronous and active-high; clears all state on the clk rising edge.
- in  input  N  parallel data word to be read out.
- load  input  1  capture request; sampled only in IDLE.
- sout  output  1  current serial bit; 0 whenever sout_valid=0.
- sout_valid  output  1  sout holds a valid beat.
- sout_ready  input  1  downstream accepts the beat this cycle.
- busy  output  1  transfer in progress (SHIFT or PARITY state).
- done  output  1  one-cycle pulse after the final beat is accepted.
- bits_left  output  $clog2(N+1)  data beats remaining, including the current beat; 0 in IDLE/DONE.

Behaviour:
- States: IDLE, SHIFT, PARITY (only present when the optional feature is compiled in), DONE.
- Reset: clear=1 at a clk edge forces IDLE on that edge.
  - shift register and bits_left go to 0; sout=0, sout_valid=0, busy=0, done=0.
  - clear has priority over every other input in the same cycle, including load and an accepted beat.
  - clear mid-transfer aborts the word; no done pulse is generated.
- IDLE:
  - load=1 at an edge: capture in into the shift register, set bits_left=N, go to SHIFT.
  - sout_valid is high in the first cycle after that edge (load-to-first-beat latency: 1 cycle).
- SHIFT:
  - sout_valid=1, busy=1.
  - sout = shift register bit N-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
- Beat transfer: occurs at an edge where sout_valid=1 and sout_ready=1.
  - Shift the register by one toward the output end; zero-fill.
  - bits_left decrements by 1.
- Backpressure: while sout_ready=0, sout, sout_valid, bits_left and the shift register hold unchanged.
- Last data beat (bits_left=1) accepted: go to DONE, or to PARITY if the feature is enabled.
- DONE lasts exactly one cycle:
  - done=1, busy=0, sout_valid=0.
  - Then return to IDLE unconditionally.
- load outside IDLE (SHIFT, PARITY, DONE) is ignored. A new word can be captured no earlier than the first IDLE cycle after DONE.
- Throughput with sout_ready held high: N beats in N consecutive cycles, done on cycle N+1, next load accepted on cycle N+2.
- in is sampled only at the capture edge; later changes to in do not affect the stream.

Optional Feature:
- Macro: REG_READER_PARITY_EN.
- Defined:
  - After the last data beat, enter PARITY for one extra beat.
  - Beat value: sout = XOR of all N captured bits (even parity).
  - sout_valid=1, busy=1, bits_left=0.
  - Same handshake and backpressure rules as SHIFT; on acceptance go to DONE.
  - Total N+1 beats per word.
- Undefined: PARITY state and parity logic are absent; N beats per word.

Test Plan:
- Reset: assert clear 2 cycles with load=1 and in=8'hFF -> sout_valid=0, busy=0, done=0, bits_left=0, sout=0; no capture occurs.
- Basic stream: N=8, MSB_FIRST=1, sout_ready=1, in=8'hA5, load pulsed 1 cycle -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; bits_left 8..1; busy high 8 cycles; done high exactly on cycle 9.
  - Repeat with MSB_FIRST=0 -> stream 1,0,1,0,0,1,0,1 (bit 0 first; the pattern is palindromic).
  - Repeat with in=8'h01 -> stream 1 then seven 0s.
- Backpressure: 8'hA5, sout_ready=0 for 3 cycles after the 2nd beat is accepted -> sout holds 1, bits_left holds 6, sout_valid stays 1; stream resumes unchanged and done is delayed by exactly 3 cycles.
- Ignored load: while streaming 8'hA5, pulse load with in=8'hFF in SHIFT and in DONE -> stream is still A5; no second transfer starts.
- Mid-stream clear: clear asserted after 4 beats of 8'hA5 -> next cycle all outputs 0 and no done pulse; then load 8'h3C -> full stream 0,0,1,1,1,1,0,0 and done.
- Parity (REG_READER_PARITY_EN defined):
  - 8'hA5 -> 9th beat sout=0, done on cycle 10.
  - 8'h07 -> 9th beat sout=1.
  - With the macro undefined, 8'h07 -> done on cycle 9.
